// File: rtl/arm_pipelined_multiply_unit.sv
// -----------------------------------------------------------------------------
// arm_pipelined_multiply_unit
//
// Iterative shift-add multiplier for MUL/MLA in the Execute stage. One
// multiplier bit is consumed per RUN cycle. The unit stalls the pipeline
// through o_Busy while it works. It then presents the product, the {N,Z,C,V}
// flags and a {NZ write, CV write} strobe together with a one-cycle o_Done
// pulse.
//
// Optional feature (macro ARM_PIPELINED_MUL_EARLY_TERM_EN):
//   When this macro is defined, RUN ends after the step in which the shifted
//   multiplier becomes zero, so latency depends on the operand. When it is
//   undefined, RUN always lasts DATA_WIDTH cycles.
//
// Ports:
//   i_CLK, i_NRESET        clock (rising edge), async active-low reset
//   i_Start                MUL/MLA in Execute with condition passed (level)
//   i_Accumulate           1 = MLA (adds i_SrcAcc), 0 = MUL
//   i_Set_Flags            S bit
//   i_SrcA / i_SrcB        multiplicand (Rm) / multiplier (Rs)
//   i_SrcAcc               accumulate operand (Rn)
//   i_Flags_In             current NZCV; C and V are passed through
//   i_Flush                abort current operation
//   o_Busy                 stall request to hazard unit (combinational)
//   o_Done                 one-cycle completion pulse
//   o_Result               low DATA_WIDTH bits of the product (+ Rn)
//   o_Flags                {N, Z, C, V} of the completed operation
//   o_Flag_Write           {NZ write, CV write}; non-zero only with o_Done
// -----------------------------------------------------------------------------
module arm_pipelined_multiply_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_CLK,
    input  logic                  i_NRESET,
    input  logic                  i_Start,
    input  logic                  i_Accumulate,
    input  logic                  i_Set_Flags,
    input  logic [DATA_WIDTH-1:0] i_SrcA,
    input  logic [DATA_WIDTH-1:0] i_SrcB,
    input  logic [DATA_WIDTH-1:0] i_SrcAcc,
    input  logic [3:0]            i_Flags_In,
    input  logic                  i_Flush,
    output logic                  o_Busy,
    output logic                  o_Done,
    output logic [DATA_WIDTH-1:0] o_Result,
    output logic [3:0]            o_Flags,
    output logic [1:0]            o_Flag_Write
);

    localparam int CW = $clog2(DATA_WIDTH) + 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] mcand;
    logic [DATA_WIDTH-1:0] mplier;
    logic [DATA_WIDTH-1:0] acc;
    logic [CW-1:0]         count;
    logic                  s_bit;
    logic [1:0]            cv;

    // Values after the current RUN step.
    logic [DATA_WIDTH-1:0] acc_step;
    logic [DATA_WIDTH-1:0] mcand_step;
    logic [DATA_WIDTH-1:0] mplier_step;
    logic                  last_step;

    assign acc_step    = mplier[0] ? acc + mcand : acc;
    assign mcand_step  = mcand << 1;
    assign mplier_step = mplier >> 1;

`ifdef ARM_PIPELINED_MUL_EARLY_TERM_EN
    // Once no multiplier bits remain, further steps cannot change acc.
    assign last_step = (count == LAST_COUNT) || (mplier_step == '0);
`else
    assign last_step = (count == LAST_COUNT);
`endif

    // The stall must be raised in the accept cycle itself, so this is
    // combinational. It is gated by reset so the hazard unit sees no stall
    // while the unit is held in reset.
    assign o_Busy = i_NRESET &
                    ((state == RUN) | ((state == IDLE) & i_Start & ~i_Flush));

    always_ff @(posedge i_CLK or negedge i_NRESET) begin
        if (!i_NRESET) begin
            state        <= IDLE;
            mcand        <= '0;
            mplier       <= '0;
            acc          <= '0;
            count        <= '0;
            s_bit        <= 1'b0;
            cv           <= 2'b00;
            o_Done       <= 1'b0;
            o_Result     <= '0;
            o_Flags      <= 4'b0000;
            o_Flag_Write <= 2'b00;
        end else begin
            // Pulse outputs. They are set only on the RUN->DONE transition.
            o_Done       <= 1'b0;
            o_Flag_Write <= 2'b00;
            if (i_Flush) begin
                // Abort: result and flags keep their previous values.
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (i_Start) begin
                            mcand  <= i_SrcA;
                            mplier <= i_SrcB;
                            acc    <= i_Accumulate ? i_SrcAcc : '0;
                            s_bit  <= i_Set_Flags;
                            cv     <= i_Flags_In[1:0];
                            count  <= '0;
                            state  <= RUN;
                        end
                    end
                    RUN: begin
                        acc    <= acc_step;
                        mcand  <= mcand_step;
                        mplier <= mplier_step;
                        count  <= count + CW'(1);
                        if (last_step) begin
                            state        <= DONE;
                            o_Done       <= 1'b1;
                            o_Result     <= acc_step;
                            o_Flags      <= {acc_step[DATA_WIDTH-1],
                                             (acc_step == '0), cv};
                            o_Flag_Write <= {s_bit, 1'b0};
                        end
                    end
                    // i_Start here belongs to the instruction that just
                    // finished, so it is ignored.
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_arm_pipelined_multiply_unit.sv
// -----------------------------------------------------------------------------
// tb_arm_pipelined_multiply_unit
//
// Self-checking bench. It applies a table of directed MUL/MLA vectors, then
// several hand-written sequences (flush, reset mid-operation, start held
// through DONE), then random operations. Each result is compared against a
// plain arithmetic model of the product.
// -----------------------------------------------------------------------------
module tb_arm_pipelined_multiply_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        accen;
    logic        setf;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic [31:0] src_acc;
    logic [3:0]  flags_in;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [3:0]  flags;
    logic [1:0]  fw;

    int n_checks = 0;
    int n_fail   = 0;

    arm_pipelined_multiply_unit #(.DATA_WIDTH(32)) dut (
        .i_CLK        (clk),
        .i_NRESET     (rst_n),
        .i_Start      (start),
        .i_Accumulate (accen),
        .i_Set_Flags  (setf),
        .i_SrcA       (src_a),
        .i_SrcB       (src_b),
        .i_SrcAcc     (src_acc),
        .i_Flags_In   (flags_in),
        .i_Flush      (flush),
        .o_Busy       (busy),
        .o_Done       (done),
        .o_Result     (result),
        .o_Flags      (flags),
        .o_Flag_Write (fw)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference latency from the accept cycle to o_Done.
    function automatic int model_lat(input logic [31:0] b);
`ifdef ARM_PIPELINED_MUL_EARLY_TERM_EN
        int hb;
        hb = -1;
        for (int i = 0; i < 32; i++) if (b[i]) hb = i;
        return (hb < 0) ? 2 : hb + 2;
`else
        return 33;
`endif
    endfunction

    function automatic logic [31:0] model_res(input logic [31:0] a, b, c, input logic en);
        logic [63:0] p;
        p = 64'(a) * 64'(b) + (en ? 64'(c) : 64'd0);
        return p[31:0];
    endfunction

    // Issue one operation and follow it to o_Done. Start is held while busy,
    // as the stalled pipeline would do. flags_in is scrambled after the
    // accept cycle so that C/V must come from the latched value.
    task automatic run_op(input string name, input logic ae, input logic s,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                          input logic [3:0] fl, input logic [31:0] er,
                          input logic [3:0] ef, input logic [1:0] efw, input bit keep);
        int lat, k;
        bit got, busy_ok;
        lat = model_lat(b);
        @(negedge clk);
        start = 1'b1; accen = ae; setf = s; src_a = a; src_b = b; src_acc = c; flags_in = fl;
        #1;
        check({name, "_busy_T"}, 64'(busy), 64'd1);
        k = 0; got = 0; busy_ok = 1;
        while (!got && k < 60) begin
            @(negedge clk);
            k++;
            if (k == 1) flags_in = ~fl;
            if (done) got = 1;
            else if (busy !== 1'b1) busy_ok = 0;
        end
        check({name, "_done_seen"}, 64'(got), 64'd1);
        if (got) begin
            check({name, "_latency"}, 64'(k), 64'(lat));
            check({name, "_result"}, 64'(result), 64'(er));
            check({name, "_flags"}, 64'(flags), 64'(ef));
            check({name, "_flag_write"}, 64'(fw), 64'(efw));
            check({name, "_busy_at_done"}, 64'(busy), 64'd0);
        end
        check({name, "_busy_while_running"}, 64'(busy_ok), 64'd1);
        if (!keep) start = 1'b0;
        @(negedge clk);
        check({name, "_single_done"}, 64'(done), 64'd0);
        check({name, "_fw_after"}, 64'(fw), 64'd0);
        check({name, "_busy_idle"}, 64'(busy), 64'(keep));
    endtask

    typedef struct {
        logic        ae;
        logic        s;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [3:0]  fl;
        logic [31:0] er;
        logic [3:0]  ef;
        logic [1:0]  efw;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic [31:0] ra, rb, rc, er;
        logic [3:0]  rf, ef;
        logic        rae, rs;
        bit          never_done;

        vecs[0] = '{1'b0, 1'b1, 32'd7,        32'd6,          32'd0,    4'b0011, 32'd42,         4'b0011, 2'b10};
        vecs[1] = '{1'b1, 1'b1, 32'hFFFFFFFF, 32'd1,          32'd1,    4'b0010, 32'd0,          4'b0110, 2'b10};
        vecs[2] = '{1'b0, 1'b1, 32'h80000000, 32'd1,          32'd0,    4'b0001, 32'h80000000,   4'b1001, 2'b10};
        vecs[3] = '{1'b0, 1'b0, 32'd3,        32'd5,          32'd0,    4'b1111, 32'd15,         4'b0011, 2'b00};
        vecs[4] = '{1'b1, 1'b1, 32'h00010000, 32'h00010000,   32'd5,    4'b0000, 32'd5,          4'b0000, 2'b10};
        vecs[5] = '{1'b1, 1'b1, 32'h00001234, 32'd0,          32'h77,   4'b1110, 32'h77,         4'b0010, 2'b10};
        vecs[6] = '{1'b0, 1'b1, 32'd9,        32'h80000000,   32'd0,    4'b0000, 32'h80000000,   4'b1000, 2'b10};
        vecs[7] = '{1'b0, 1'b1, 32'd2,        32'd3,          32'd100,  4'b0001, 32'd6,          4'b0001, 2'b10};

        rst_n = 1'b0; start = 1'b1; accen = 1'b0; setf = 1'b0;
        src_a = 32'd0; src_b = 32'd0; src_acc = 32'd0; flags_in = 4'd0; flush = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_result", 64'(result), 64'd0);
        check("reset_flags", 64'(flags), 64'd0);
        check("reset_fw", 64'(fw), 64'd0);
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_busy", 64'(busy), 64'd0);

        for (int i = 0; i < 8; i++)
            run_op($sformatf("vec%0d", i), vecs[i].ae, vecs[i].s, vecs[i].a, vecs[i].b,
                   vecs[i].c, vecs[i].fl, vecs[i].er, vecs[i].ef, vecs[i].efw, 1'b0);

        // Start held through DONE: one pulse, then a fresh accept in IDLE.
        run_op("hold", 1'b0, 1'b1, 32'd7, 32'd6, 32'd0, 4'b0011, 32'd42, 4'b0011, 2'b10, 1'b1);
        @(negedge clk);
        start = 1'b0;
        #1;
        check("hold_restarted_run", 64'(busy), 64'd1);
        check("hold_no_done", 64'(done), 64'd0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("hold_flushed_idle", 64'(busy), 64'd0);
        check("hold_result_kept", 64'(result), 64'd42);

        // Flush at RUN cycle 10.
        @(negedge clk);
        start = 1'b1; accen = 1'b0; setf = 1'b1; src_a = 32'd9; src_b = 32'hFFFFFFFF; flags_in = 4'b0000;
        repeat (10) @(negedge clk);
        start = 1'b0; flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("flush_idle", 64'(busy), 64'd0);
        check("flush_result_kept", 64'(result), 64'd42);
        check("flush_flags_kept", 64'(flags), 64'b0011);
        never_done = 1;
        repeat (40) begin
            @(negedge clk);
            if (done) never_done = 0;
        end
        check("flush_no_done", 64'(never_done), 64'd1);

        // Flush beats start in IDLE.
        @(negedge clk);
        start = 1'b1; flush = 1'b1;
        #1;
        check("flush_start_busy", 64'(busy), 64'd0);
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        #1;
        check("flush_start_idle", 64'(busy), 64'd0);

        // Reset mid-RUN.
        @(negedge clk);
        start = 1'b1; src_a = 32'd3; src_b = 32'hFFFFFFFF;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_result", 64'(result), 64'd0);
        check("rst_mid_flags", 64'(flags), 64'd0);
        check("rst_mid_done", 64'(done), 64'd0);
        check("rst_mid_fw", 64'(fw), 64'd0);
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b1;

        // Random operations against the arithmetic model.
        for (int i = 0; i < 25; i++) begin
            ra  = $urandom;
            rb  = $urandom >> $urandom_range(0, 31);
            rc  = $urandom;
            rf  = 4'($urandom);
            rae = 1'($urandom);
            rs  = 1'($urandom);
            er  = model_res(ra, rb, rc, rae);
            ef  = {er[31], (er == 32'd0), rf[1:0]};
            run_op($sformatf("rnd%0d", i), rae, rs, ra, rb, rc, rf, er, ef, {rs, 1'b0}, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/arm_pipelined_multiply_unit.md
# arm_pipelined_multiply_unit

Iterative shift-add multiplier for MUL/MLA in the Execute stage of the pipelined ARM core. It is the producer side of the flag path: it generates the result and the NZ flags plus a 2-bit flag-write strobe in the same {NZ, CV} format that the condition unit consumes. While busy it stalls the pipeline through the hazard unit, and it returns the product with a one-cycle done pulse.

## Interface
Parameters:
- DATA_WIDTH, 32, operand/result width; iteration counter is $clog2(DATA_WIDTH)+1 bits

Ports:
- i_CLK  in  1  clock, rising edge
- i_NRESET  in  1  asynchronous active-low reset
- i_Start  in  1  MUL/MLA in Execute, condition passed; level, held while stalled
- i_Accumulate  in  1  1 = MLA (add i_SrcAcc), 0 = MUL
- i_Set_Flags  in  1  S bit
- i_SrcA  in  DATA_WIDTH  multiplicand (Rm)
- i_SrcB  in  DATA_WIDTH  multiplier (Rs)
- i_SrcAcc  in  DATA_WIDTH  accumulate operand (Rn)
- i_Flags_In  in  4  current NZCV
- i_Flush  in  1  abort current operation
- o_Busy  out  1  stall request to hazard unit
- o_Done  out  1  one-cycle completion pulse
- o_Result  out  DATA_WIDTH  product, low DATA_WIDTH bits
- o_Flags  out  4  {N, Z, C, V} for the completed operation
- o_Flag_Write  out  2  {NZ write, CV write}, valid only with o_Done

## Operation
- States: IDLE, RUN, DONE.
- IDLE: if i_Start & ~i_Flush, latch multiplicand=i_SrcA, multiplier=i_SrcB, acc=(i_Accumulate ? i_SrcAcc : 0), S=i_Set_Flags, CV=i_Flags_In[1:0], count=0 → RUN.
- RUN, each cycle: if multiplier[0], acc += multiplicand (mod 2^DATA_WIDTH); multiplicand <<= 1; multiplier >>= 1; count++. → DONE after the DATA_WIDTH-th step.
- DONE: o_Done=1, o_Result=acc, o_Flags={acc[MSB], acc==0, CV}, o_Flag_Write={S,0}. → IDLE unconditionally. i_Start ignored in DONE and RUN (same instruction still in Execute).
- o_Busy = (state==RUN) | (state==IDLE & i_Start & ~i_Flush); combinational.
- o_Result/o_Flags hold their last values in IDLE and RUN. o_Flag_Write=00 outside DONE.
- C and V are never modified; they are passed through from the latched i_Flags_In.
- Overflow beyond DATA_WIDTH bits is discarded.
- i_Flush in any state: next state IDLE, no o_Done, o_Result/o_Flags unchanged. Flush wins over simultaneous i_Start in IDLE.
- Reset (any state, mid-operation included): state IDLE, o_Result=0, o_Flags=0, o_Done=0, o_Flag_Write=00, internal regs 0; o_Busy=0 while i_NRESET low.

## Timing
- i_Start sampled in IDLE at cycle T: o_Busy high T..T+DATA_WIDTH, o_Done and result at T+DATA_WIDTH+1 (33-cycle latency at 32 bits), o_Busy low that cycle.
- Back-to-back: new i_Start accepted in the cycle after DONE, at the earliest.
- o_Done never asserts in two consecutive cycles.

## Configuration
- ARM_PIPELINED_MUL_EARLY_TERM_EN defined: RUN exits to DONE after the step in which the shifted multiplier becomes zero (or after DATA_WIDTH steps). One RUN cycle minimum; DONE at T+1+(index of highest set bit of i_SrcB)+1; i_SrcB=0 gives DONE at T+2.
- Undefined: always DATA_WIDTH RUN cycles, fixed latency.

## Test plan
- MUL 7×6, S=1, flags_in=0011 → o_Done at T+33, o_Result=42, o_Flags=0011, o_Flag_Write=10.
- MLA 0xFFFFFFFF×1 + 1, S=1 → o_Result=0, o_Flags={0,1,C_in,V_in}; MUL 0x80000000×1 → N=1.
- S=0 → o_Flag_Write=00 on done pulse; o_Busy high exactly 33 cycles from T.
- i_Flush at RUN cycle 10 → no o_Done, o_Result keeps previous 42, IDLE next cycle; reset asserted mid-RUN → all outputs 0 immediately.
- EARLY_TERM_EN: i_SrcB=5 → DONE at T+4; i_SrcB=0 → DONE at T+2 with result=acc operand; i_SrcB=0x80000000 → T+33.
- i_Start held high through DONE → single o_Done, no restart until the next IDLE cycle.
